// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding
// and the line levels that mark idle and start-of-frame.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_PARITY    = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity holds when data bits plus the parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [15:0] bits, input logic par_bit);
        return (^bits ^ par_bit) == 1'b0;
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// Valid/ready holding register for received words. A word offered while
// an unconsumed word is held (and not being accepted) is dropped and flagged.
module rx_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overrun
);

    // Handshake: a word transfers at a rising edge where valid and ready are
    // both high; valid never drops without that transfer, and data is frozen
    // while valid is high and ready is low.
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              accept;

    assign accept = valid_q && ready;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (load) begin
            if (!valid_q || accept) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

    data_stable_a: assert property (@(posedge clock) disable iff (reset)
        (valid_q && !ready) |=> (data_q == $past(data_q)));

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity,
// stop bit. Good words go to a valid/ready holding register.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              busy_q, busy_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              deliver;
    logic              par_ok;

    assign par_ok = PARITY_EN ? even_parity_ok(16'(shift_q), par_q) : 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        par_d   = par_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        deliver = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d == START_LEVEL) begin
                    state_d = ST_DATA;
                    count_d = '0;
                end
            end
            ST_DATA: begin
                shift_d[count_q] = d;
                count_d          = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                par_d   = d;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                // A bad stop bit and bad parity are reported together.
                perr_d = !par_ok;
                if (d == LINE_IDLE) begin
                    deliver = par_ok;
                    state_d = ST_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (d == LINE_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // The hold register sees the shift register before the stop edge,
    // so the word it loads is the one just completed.
    rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .clock     (clock),
        .reset     (reset),
        .load      (deliver),
        .load_data (shift_q),
        .ready     (ready),
        .data      (data),
        .valid     (valid),
        .overrun   (overrun)
    );

    assign busy       = busy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (DATA_W=8, PARITY_EN=1):
// vector table, directed corner sequences, then randomized frames.
module tb_serial_frame_rx;

    localparam int DATA_W = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              d     = 1'b1;
    logic              ready = 1'b0;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              busy;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    serial_frame_rx #(.DATA_W(DATA_W), .PARITY_EN(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .d          (d),
        .ready      (ready),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    int              n_checks = 0;
    int              n_errors = 0;
    int              ovr_seen = 0;
    logic            exp_valid = 1'b0;
    logic [7:0]      exp_data  = 8'h00;
    logic [7:0]      exp_q[$];

    typedef struct {
        logic [7:0] word;
        logic       par_flip;
        logic       stop_bit;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rv(input int m);
        return (m == 2) ? 1'($urandom_range(0, 1)) : (m != 0);
    endfunction

    // One clock: update the reference model for this edge, drive, clock, compare.
    task automatic cyc(input logic d_in, input logic rdy_in, input logic rst_in,
                       input logic good, input logic [7:0] word,
                       input logic perr, input logic ferr, input logic busy_exp);
        logic       exp_ovr;
        logic [7:0] acc;
        exp_ovr = 1'b0;
        if (rst_in) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_q.delete();
        end else begin
            if (exp_valid && rdy_in) begin
                if (exp_q.size() > 0) begin
                    acc = exp_q.pop_front();
                    chk("accepted_word", 16'(data), 16'(acc));
                end else begin
                    chk("scoreboard_underflow", 16'(exp_q.size()), 16'd1);
                end
            end
            if (good) begin
                if (!exp_valid || rdy_in) begin
                    exp_valid = 1'b1;
                    exp_data  = word;
                    exp_q.push_back(word);
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (exp_valid && rdy_in) begin
                exp_valid = 1'b0;
            end
        end
        d     = d_in;
        ready = rdy_in;
        reset = rst_in;
        @(posedge clock);
        #1;
        if (overrun) ovr_seen++;
        chk("valid", 16'(valid), 16'(exp_valid));
        chk("data", 16'(data), 16'(exp_data));
        chk("busy", 16'(busy), 16'(busy_exp));
        chk("parity_err", 16'(parity_err), 16'(perr));
        chk("frame_err", 16'(frame_err), 16'(ferr));
        chk("overrun", 16'(overrun), 16'(exp_ovr));
    endtask

    task automatic send_frame(input logic [7:0] word, input logic par_flip, input logic stop_bit,
                              input int rmode, input int rmode_stop);
        cyc(1'b0, rv(rmode), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DATA_W; i++) begin
            cyc(word[i], rv(rmode), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        cyc((^word) ^ par_flip, rv(rmode), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(stop_bit, rv(rmode_stop), 1'b0, stop_bit && !par_flip, word,
            par_flip, !stop_bit, !stop_bit);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b1, rdy, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic low_hold(input logic rdy);
        cyc(1'b0, rdy, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{8'h96, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

        // Reset state
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1'b1);

        // Table-driven frames with ready held high
        foreach (tbl[k]) begin
            send_frame(tbl[k].word, tbl[k].par_flip, tbl[k].stop_bit, 1, 1);
            chk("tbl_valid", 16'(valid), 16'(tbl[k].exp_valid));
            if (tbl[k].exp_valid) chk("tbl_data", 16'(data), 16'(tbl[k].exp_data));
            chk("tbl_parity_err", 16'(parity_err), 16'(tbl[k].exp_perr));
            chk("tbl_frame_err", 16'(frame_err), 16'(tbl[k].exp_ferr));
            idle(1'b1);
            chk("tbl_valid_drop", 16'(valid), 16'd0);
            chk("tbl_busy_idle", 16'(busy), 16'd0);
            idle(1'b1);
        end

        // Framing error, stuck-low line, then a normal frame
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1);
        chk("fe_pulse", 16'(frame_err), 16'd1);
        repeat (6) low_hold(1'b1);
        chk("fe_busy_hold", 16'(busy), 16'd1);
        idle(1'b1);
        send_frame(8'h81, 1'b0, 1'b1, 0, 0);
        chk("fe_next_valid", 16'(valid), 16'd1);
        chk("fe_next_data", 16'(data), 16'h81);
        idle(1'b1);

        // Overrun: two back-to-back frames with ready low
        ovr_seen = 0;
        send_frame(8'h11, 1'b0, 1'b1, 0, 0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 0);
        chk("ovr_data_kept", 16'(data), 16'h11);
        chk("ovr_valid_kept", 16'(valid), 16'd1);
        idle(1'b0);
        chk("ovr_pulse_count", 16'(ovr_seen), 16'd1);
        idle(1'b1);
        chk("ovr_cleared", 16'(valid), 16'd0);

        // Accept and deliver at the same edge
        ovr_seen = 0;
        send_frame(8'h55, 1'b0, 1'b1, 0, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 0, 1);
        chk("sim_data", 16'(data), 16'hAA);
        chk("sim_valid", 16'(valid), 16'd1);
        chk("sim_no_overrun", 16'(ovr_seen), 16'd0);
        idle(1'b1);

        // Reset at data bit 4 of 0xF0 while a word is held
        send_frame(8'h33, 1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_all_zero", 16'({data, valid, busy, parity_err, frame_err, overrun}), 16'd0);
        idle(1'b1);
        idle(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1);
        chk("rst_next_data", 16'(data), 16'h5A);
        chk("rst_next_valid", 16'(valid), 16'd1);
        idle(1'b1);

        // Randomized frames, errors and ready
        for (int f = 0; f < 60; f++) begin
            logic [7:0] w;
            logic       flip;
            logic       stop;
            w    = 8'($urandom_range(0, 255));
            flip = ($urandom_range(0, 5) == 0);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(w, flip, stop, 2, 2);
            if (!stop) begin
                repeat ($urandom_range(0, 3)) low_hold(rv(2));
                idle(rv(2));
            end
            repeat ($urandom_range(0, 2)) idle(rv(2));
        end
        repeat (3) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
